d_bus_router: RTL

Parametrised data-side bus router between the core load/store unit and `NSLV` memory-mapped targets (RAM, IO, peripherals). It decodes each request against a per-slave base/mask region table and forwards it to exactly one slave. A registered state machine tracks one outstanding transaction and returns the slave's data, or an error for unmapped addresses and optional timeouts. It replaces the fixed two-way RAM/IO split with N regions, per-slave wait states, and error reporting.

---
 rtl/d_bus_router.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/d_bus_router.sv
// d_bus_router: data-side bus router from the load/store unit to NSLV memory-mapped slaves.
// Each request is decoded against a per-slave base/mask table (lowest index wins on overlap)
// and forwarded to one slave; one transaction is outstanding at a time.
// Optional macro D_BUS_ROUTER_TIMEOUT_EN adds a BUSY wait limit of TIMEOUT_CYC cycles that
// completes the transaction with err=1.
module d_bus_router #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_LEN = 16,
  parameter int unsigned NSLV     = 4,
  parameter logic [NSLV*ADDR_LEN-1:0] REGION_BASE = {16'hC000, 16'h8000, 16'h4000, 16'h0000},
  parameter logic [NSLV*ADDR_LEN-1:0] REGION_MASK = {16'hC000, 16'hC000, 16'hC000, 16'hC000},
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic [ADDR_LEN-1:0]      addr_i,
  input  logic                     rd_req_i,
  input  logic                     wr_req_i,
  input  logic [XLEN/8-1:0]        be_i,
  input  logic [XLEN-1:0]          wr_data_i,
  output logic                     rd_ready_o,
  output logic                     wr_ready_o,
  output logic [XLEN-1:0]          rd_data_o,
  output logic                     err_o,
  output logic [NSLV*ADDR_LEN-1:0] s_addr_o,
  output logic [NSLV-1:0]          s_rd_en_o,
  output logic [NSLV-1:0]          s_wr_en_o,
  output logic [XLEN/8-1:0]        s_be_o,
  output logic [XLEN-1:0]          s_wr_data_o,
  input  logic [NSLV*XLEN-1:0]     s_rd_data_i,
  input  logic [NSLV-1:0]          s_rd_ready_i,
  input  logic [NSLV-1:0]          s_wr_ready_i
);

  localparam int unsigned BeW = XLEN / 8;

  typedef enum logic [1:0] {StIdle, StBusy, StErr, StDone} state_e;

  state_e                state_q;
  logic [NSLV-1:0]       sel_q;
  logic                  wr_q;
  logic [ADDR_LEN-1:0]   addr_q;
  logic [BeW-1:0]        be_q;
  logic [XLEN-1:0]       wdata_q;
  logic [NSLV-1:0]       rd_en_q;
  logic [NSLV-1:0]       wr_en_q;
  logic                  rd_ready_q;
  logic                  wr_ready_q;
  logic [XLEN-1:0]       rd_data_q;
  logic                  err_q;

`ifdef D_BUS_ROUTER_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CntW-1:0]       cnt_q;
`endif

  logic [NSLV-1:0]       hit;
  logic [XLEN-1:0]       sel_rd_data;
  logic                  sel_ready;

  // Region decode; descending scan so the lowest matching index is the one left set.
  always_comb begin
    hit = '0;
    for (int i = int'(NSLV) - 1; i >= 0; i--) begin
      if ((addr_i & REGION_MASK[i*ADDR_LEN +: ADDR_LEN]) == REGION_BASE[i*ADDR_LEN +: ADDR_LEN])
      begin
        hit    = '0;
        hit[i] = 1'b1;
      end
    end
  end

  // Read-data mux and ready detect for the latched one-hot select; other slaves are ignored.
  always_comb begin
    sel_rd_data = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (sel_q[i]) sel_rd_data = sel_rd_data | s_rd_data_i[i*XLEN +: XLEN];
    end
    sel_ready = |(sel_q & (wr_q ? s_wr_ready_i : s_rd_ready_i));
  end

  // Per-slave offset of the latched address.
  always_comb begin
    s_addr_o = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      s_addr_o[i*ADDR_LEN +: ADDR_LEN] = addr_q & ~REGION_MASK[i*ADDR_LEN +: ADDR_LEN];
    end
  end

  // Transaction FSM with all master/slave control outputs registered.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rd_en_q    <= '0;
      wr_en_q    <= '0;
      rd_ready_q <= 1'b0;
      wr_ready_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
`ifdef D_BUS_ROUTER_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      rd_ready_q <= 1'b0;
      wr_ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rd_req_i || wr_req_i) begin
            // Write takes precedence when both requests are raised together.
            wr_q <= wr_req_i;
            if (|hit) begin
              sel_q   <= hit;
              addr_q  <= addr_i;
              be_q    <= be_i;
              wdata_q <= wr_data_i;
              rd_en_q <= wr_req_i ? '0 : hit;
              wr_en_q <= wr_req_i ? hit : '0;
`ifdef D_BUS_ROUTER_TIMEOUT_EN
              cnt_q   <= '0;
`endif
              state_q <= StBusy;
            end else begin
              sel_q   <= '0;
              state_q <= StErr;
            end
          end
        end
        StBusy: begin
          if (sel_ready) begin
            if (!wr_q) rd_data_q <= sel_rd_data;
            err_q      <= 1'b0;
            rd_en_q    <= '0;
            wr_en_q    <= '0;
            rd_ready_q <= ~wr_q;
            wr_ready_q <= wr_q;
            state_q    <= StDone;
          end
`ifdef D_BUS_ROUTER_TIMEOUT_EN
          // Last allowed BUSY cycle with no ready: give up and report an error.
          else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
            err_q      <= 1'b1;
            rd_data_q  <= '0;
            rd_en_q    <= '0;
            wr_en_q    <= '0;
            rd_ready_q <= ~wr_q;
            wr_ready_q <= wr_q;
            state_q    <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StErr: begin
          err_q      <= 1'b1;
          rd_data_q  <= '0;
          rd_ready_q <= ~wr_q;
          wr_ready_q <= wr_q;
          state_q    <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rd_ready_o  = rd_ready_q;
  assign wr_ready_o  = wr_ready_q;
  assign rd_data_o   = rd_data_q;
  assign err_o       = err_q;
  assign s_rd_en_o   = rd_en_q;
  assign s_wr_en_o   = wr_en_q;
  assign s_be_o      = be_q;
  assign s_wr_data_o = wdata_q;

endmodule
